regbag: RTL and testbench

// Integer register file ("regbag") of the 5-stage RV32I core. Consumer end
// of the WB write port driven by the MEM/WB pipeline register.
// - Commits one write per cycle.
// - Serves two combinational read ports to ID and one debug read port.
// - Write-to-read bypass, so ID sees a value in the same cycle WB writes it.
// - Counts committed writes, for trace and retire checking.
//

---
 rtl/regbag_if.sv | 33 +++
 rtl/regbag.sv | 61 ++++++
 tb/tb_regbag.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/regbag_if.sv
// Write-back and read-port bundle of the RV32I integer register file.
// master = pipeline side (MEM/WB + ID + debug); slave = register file.
interface regbag_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) ();
    logic            regbag_w_en;
    logic [AW-1:0]   regbag_w_addr;
    logic [XLEN-1:0] regbag_w_data;
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [31:0]     wr_count;
    logic [AW-1:0]   wr_last_addr;
    logic            wr_pulse;

    modport master (
        output regbag_w_en, regbag_w_addr, regbag_w_data,
        output rs1_addr, rs2_addr, dbg_addr,
        input  rs1_data, rs2_data, dbg_data,
        input  wr_count, wr_last_addr, wr_pulse
    );

    modport slave (
        input  regbag_w_en, regbag_w_addr, regbag_w_data,
        input  rs1_addr, rs2_addr, dbg_addr,
        output rs1_data, rs2_data, dbg_data,
        output wr_count, wr_last_addr, wr_pulse
    );
endinterface

// File: rtl/regbag.sv
// RV32I integer register file: one WB write port, two ID read ports with
// optional same-cycle WB forwarding, one non-forwarding debug port, write trace.
module regbag #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    regbag_if.slave  bus
);
    localparam int NRD = 3;  // rs1, rs2, dbg

    logic [XLEN-1:0]          r_mem [NREG];
    logic [31:0]              r_wr_count;
    logic [AW-1:0]            r_wr_last_addr;
    logic                     r_wr_pulse;

    logic                     w_commit;
    logic [NRD-1:0][AW-1:0]   w_rd_addr;
    logic [NRD-1:0][XLEN-1:0] w_rd_data;

    // x0 writes are dropped here, so r_mem[0] stays zero and needs no read-side guard
    assign w_commit = bus.regbag_w_en && (bus.regbag_w_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
            r_wr_count     <= '0;
            r_wr_last_addr <= '0;
            r_wr_pulse     <= 1'b0;
        end else begin
            r_wr_pulse <= w_commit;
            if (w_commit) begin
                r_mem[bus.regbag_w_addr] <= bus.regbag_w_data;
                r_wr_count               <= r_wr_count + 32'd1;
                r_wr_last_addr           <= bus.regbag_w_addr;
            end
        end
    end

    assign w_rd_addr = {bus.dbg_addr, bus.rs2_addr, bus.rs1_addr};

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic w_hit;
        // debug port (p == NRD-1) always shows the stored value
        assign w_hit = (BYPASS != 0) && (p != NRD - 1) && w_commit &&
                       (w_rd_addr[p] == bus.regbag_w_addr);
        // gate with rst_n so a forwarded write cannot leak out while reset is held
        assign w_rd_data[p] = !rst_n ? '0 :
                              w_hit  ? bus.regbag_w_data : r_mem[w_rd_addr[p]];
    end

    assign bus.rs1_data     = w_rd_data[0];
    assign bus.rs2_data     = w_rd_data[1];
    assign bus.dbg_data     = w_rd_data[2];
    assign bus.wr_count     = r_wr_count;
    assign bus.wr_last_addr = r_wr_last_addr;
    assign bus.wr_pulse     = r_wr_pulse;
endmodule

// File: tb/tb_regbag.sv
// Scoreboard bench for regbag: one forwarding and one non-forwarding instance
// driven identically, checked against an array-based architectural model.
module tb_regbag;
    logic clk;
    logic rst_n;

    regbag_if #(.XLEN(32), .AW(5)) u_if1 ();
    regbag_if #(.XLEN(32), .AW(5)) u_if0 ();

    regbag #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(u_if1));
    regbag #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(u_if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] rs1b, rs2b, rs1s, rs2s, dbg, cnt;
        logic [4:0]  last;
        logic        pulse;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_reg [32];
    logic [31:0] m_cnt;
    logic [4:0]  m_last;
    logic        m_pulse;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_cyc  = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Architectural view: read = last committed value (or this cycle's write when forwarding),
    // trace outputs reflect writes committed at earlier edges.
    task automatic cyc(input bit rst, input bit wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        exp_t e;
        bit   commit;
        @(posedge clk);
        #2;
        rst_n = rst;
        u_if1.regbag_w_en = wen; u_if1.regbag_w_addr = wa; u_if1.regbag_w_data = wd;
        u_if1.rs1_addr = a1; u_if1.rs2_addr = a2; u_if1.dbg_addr = ad;
        u_if0.regbag_w_en = wen; u_if0.regbag_w_addr = wa; u_if0.regbag_w_data = wd;
        u_if0.rs1_addr = a1; u_if0.rs2_addr = a2; u_if0.dbg_addr = ad;
        commit = rst && wen && (wa != 0);
        e.cyc = n_cyc++;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
            m_cnt = '0; m_last = '0; m_pulse = 1'b0;
            e.rs1b = '0; e.rs2b = '0; e.rs1s = '0; e.rs2s = '0; e.dbg = '0;
        end else begin
            e.rs1s = m_reg[a1];
            e.rs2s = m_reg[a2];
            e.rs1b = (commit && a1 == wa) ? wd : m_reg[a1];
            e.rs2b = (commit && a2 == wa) ? wd : m_reg[a2];
            e.dbg  = m_reg[ad];
        end
        e.cnt = m_cnt; e.last = m_last; e.pulse = m_pulse;
        q.push_back(e);
        if (rst) begin
            m_pulse = commit;
            if (commit) begin
                m_reg[wa] = wd;
                m_cnt     = m_cnt + 1;
                m_last    = wa;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rs1_byp",   e.cyc, u_if1.rs1_data, e.rs1b);
                chk("rs2_byp",   e.cyc, u_if1.rs2_data, e.rs2b);
                chk("rs1_nobyp", e.cyc, u_if0.rs1_data, e.rs1s);
                chk("rs2_nobyp", e.cyc, u_if0.rs2_data, e.rs2s);
                chk("dbg_byp",   e.cyc, u_if1.dbg_data, e.dbg);
                chk("dbg_nobyp", e.cyc, u_if0.dbg_data, e.dbg);
                chk("wr_count1", e.cyc, u_if1.wr_count, e.cnt);
                chk("wr_count0", e.cyc, u_if0.wr_count, e.cnt);
                chk("wr_last1",  e.cyc, {27'd0, u_if1.wr_last_addr}, {27'd0, e.last});
                chk("wr_last0",  e.cyc, {27'd0, u_if0.wr_last_addr}, {27'd0, e.last});
                chk("wr_pulse1", e.cyc, {31'd0, u_if1.wr_pulse}, {31'd0, e.pulse});
                chk("wr_pulse0", e.cyc, {31'd0, u_if0.wr_pulse}, {31'd0, e.pulse});
            end
        end
    end

    initial begin : stim
        logic [31:0] wd;
        bit          wen;
        rst_n = 1'b0;
        u_if1.regbag_w_en = 1'b0; u_if0.regbag_w_en = 1'b0;

        // reset held with a live write on the port: every index reads 0
        for (int i = 0; i < 32; i++) cyc(0, 1, 5'd5, 32'hDEADBEEF, 5'(i), 5'd5, 5'(i));

        // basic write, then observe it and the single-cycle pulse
        cyc(1, 1, 5'd7, 32'h12345678, 5'd0, 5'd0, 5'd0);
        cyc(1, 0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        cyc(1, 0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd7);

        // x0 write dropped
        cyc(1, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        cyc(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

        // forwarding: old x3 on dbg / non-forwarding instance, new on forwarding ports
        cyc(1, 1, 5'd3, 32'hAAAA0000, 5'd0, 5'd0, 5'd0);
        cyc(1, 1, 5'd3, 32'h0000BBBB, 5'd3, 5'd3, 5'd3);
        cyc(1, 0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);

        // fresh reset, then back-to-back writes of x1..x31 and full readback
        cyc(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) cyc(1, 1, 5'(i), i * 32'h01010101, 5'(i), 5'(i - 1), 5'(i - 1));
        for (int i = 0; i < 32; i++) cyc(1, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));

        // reset dropped between edges in the middle of the write stream
        for (int i = 1; i < 10; i++) cyc(1, 1, 5'(i), i * 32'h01010101, 5'(i), 5'(i), 5'(i));
        cyc(0, 1, 5'd10, 32'h0A0A0A0A, 5'd5, 5'd9, 5'd1);
        cyc(1, 1, 5'd2, 32'h5, 5'd2, 5'd1, 5'd2);
        cyc(1, 0, 5'd0, 32'h0, 5'd2, 5'd5, 5'd2);

        // random traffic concentrated on a few registers to exercise forwarding
        for (int i = 0; i < 400; i++) begin
            wen = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (!wen && $urandom_range(0, 1) == 0) wd = 'x;
            cyc($urandom_range(0, 99) != 0, wen, 5'($urandom_range(0, 7)), wd,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
